// File: rtl/kf8237_pkg.sv
// Shared types and field encodings for the KF8237 timing-and-control block.
// Holds the transfer state enum, the mode/command bit positions and a one-hot helper.
package kf8237_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    SW = 3'd5,
    S4 = 3'd6,
    SC = 3'd7
  } state_t;

  localparam int MODE_W            = 8;
  localparam int MODE_SEL_LSB      = 0;
  localparam int MODE_TYPE_LSB     = 2;
  localparam int MODE_AUTOINIT_BIT = 4;
  localparam int MODE_DEC_BIT      = 5;
  localparam int MODE_MODE_LSB     = 6;

  localparam logic [1:0] TT_VERIFY  = 2'b00;
  localparam logic [1:0] TT_WRITE   = 2'b01;
  localparam logic [1:0] TT_READ    = 2'b10;
  localparam logic [1:0] TT_ILLEGAL = 2'b11;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  localparam int CMD_DISABLE_BIT   = 2;
  localparam int CMD_EXT_WRITE_BIT = 5;

  // Lowest set bit wins; the encoder upstream guarantees at most one bit anyway.
  function automatic logic [1:0] onehot_to_index(input logic [3:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    if (onehot[3]) idx = 2'd3;
    if (onehot[2]) idx = 2'd2;
    if (onehot[1]) idx = 2'd1;
    if (onehot[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/kf8237_mode_register_file.sv
// Four per-channel mode registers with one write port and one read port.
// The read port forwards same-cycle write data so a service starting now sees the new mode.
module kf8237_mode_register_file
  import kf8237_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              write_enable,
  input  logic [1:0]        write_select,
  input  logic [MODE_W-1:0] write_data,
  input  logic [1:0]        read_select,
  output logic [MODE_W-1:0] read_data
);

  logic [MODE_W-1:0] mode_q [4];
  logic [MODE_W-1:0] mode_d [4];

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      mode_d[ch] = mode_q[ch];
      if (write_enable && (write_select == 2'(ch))) begin
        mode_d[ch] = write_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      for (int ch = 0; ch < 4; ch++) mode_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) mode_q[ch] <= mode_d[ch];
    end
  end

  assign read_data = (write_enable && (write_select == read_select)) ? write_data
                                                                     : mode_q[read_select];

endmodule

// File: rtl/kf8237_timing_and_control.sv
// KF8237 DMA service sequencer: bus negotiation, S0-S4 transfer FSM, strobes,
// end-of-process handling, command register and sticky terminal-count status.
module kf8237_timing_and_control
  import kf8237_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_command_register,
  input  logic       write_mode_register,
  input  logic       master_clear,
  input  logic       read_status_register,
  input  logic [3:0] encoded_dma,
  input  logic       hold_acknowledge,
  input  logic       ready,
  input  logic       end_of_process_in,
  input  logic       underflow,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic [3:0] transfer_register_select,
  output logic       decrement_address_config,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       end_of_process_internal,
  output logic       end_of_process_out,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n_out,
  output logic       io_write_n_out,
  output logic       lock_bus_control,
  output logic [7:0] status
);

  state_t            state_q, state_d;
  logic [3:0]        channel_q, channel_d;
  logic [7:0]        command_q, command_d;
  logic [3:0]        tc_q, tc_d;
  logic [MODE_W-1:0] active_mode;
  logic [1:0]        mode_read_select;
  logic [1:0]        xfer_type;
  logic [1:0]        xfer_mode;
  logic              terminate;
  logic              tc_word;
  logic              bus_phase;
  logic              read_phase;
  logic              write_phase;
  logic              cmd_unused;
  logic              mode_unused;

  // A command write in the same cycle as the request must already gate the start.
  assign command_d = write_command_register ? internal_data_bus : command_q;

  // Before the channel is latched the mode of the requesting channel decides cascade.
  assign mode_read_select = (state_q == S0) ? onehot_to_index(encoded_dma)
                                            : onehot_to_index(channel_q);

  kf8237_mode_register_file u_mode_register_file (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (master_clear),
    .write_enable (write_mode_register),
    .write_select (internal_data_bus[MODE_SEL_LSB +: 2]),
    .write_data   (internal_data_bus),
    .read_select  (mode_read_select),
    .read_data    (active_mode)
  );

  assign xfer_type = active_mode[MODE_TYPE_LSB +: 2];
  assign xfer_mode = active_mode[MODE_MODE_LSB +: 2];

  always_comb begin
    state_d   = state_q;
    channel_d = channel_q;
    terminate = 1'b0;
    case (state_q)
      SI: begin
        if ((encoded_dma != 4'd0) && !command_d[CMD_DISABLE_BIT]) state_d = S0;
      end
      S0: begin
        if (encoded_dma == 4'd0) begin
          state_d = SI;
        end else if (hold_acknowledge) begin
          channel_d = encoded_dma;
          state_d   = (xfer_mode == MODE_CASCADE) ? SC : S1;
        end
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = ready ? S4 : SW;
      SW: if (ready) state_d = S4;
      S4: begin
        terminate = underflow || !end_of_process_in || (xfer_mode == MODE_SINGLE) ||
                    ((xfer_mode == MODE_DEMAND) && (encoded_dma != channel_q));
        if (terminate) begin
          state_d   = SI;
          channel_d = 4'd0;
        end else begin
          state_d = S2;
        end
      end
      SC: begin
        if (encoded_dma == 4'd0) begin
          state_d   = SI;
          channel_d = 4'd0;
        end
      end
      default: begin
        state_d   = SI;
        channel_d = 4'd0;
      end
    endcase
  end

  // Underflow in S4 always terminates, so the TC bit and EOP pulse go together.
  assign tc_word = (state_q == S4) && underflow;
  assign tc_d    = (read_status_register ? 4'd0 : tc_q) | (tc_word ? channel_q : 4'd0);

  always_ff @(posedge clock) begin
    if (!reset_n || master_clear) begin
      state_q   <= SI;
      channel_q <= 4'd0;
      command_q <= 8'd0;
      tc_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      command_q <= command_d;
      tc_q      <= tc_d;
    end
  end

  assign bus_phase   = state_q inside {S1, S2, S3, SW, S4};
  assign read_phase  = state_q inside {S2, S3, SW, S4};
  assign write_phase = (state_q inside {S3, SW, S4}) ||
                       ((state_q == S2) && command_q[CMD_EXT_WRITE_BIT]);

  assign hold_request                = (state_q != SI);
  assign dma_acknowledge_internal    = channel_q;
  assign transfer_register_select    = channel_q;
  assign decrement_address_config    = bus_phase && active_mode[MODE_DEC_BIT];
  assign address_enable              = bus_phase;
  assign address_strobe              = (state_q == S1);
  assign next_word                   = (state_q == S4);
  assign end_of_process_internal     = terminate;
  assign initialize_current_register = tc_word && active_mode[MODE_AUTOINIT_BIT];
  assign end_of_process_out          = !tc_word;
  assign lock_bus_control            = !(state_q inside {SI, S0});
  assign status                      = {encoded_dma, tc_q};

  // Verify and the illegal type 11 leave every strobe inactive.
  assign memory_read_n  = !(read_phase  && (xfer_type == TT_READ));
  assign io_write_n_out = !(write_phase && (xfer_type == TT_READ));
  assign io_read_n_out  = !(read_phase  && (xfer_type == TT_WRITE));
  assign memory_write_n = !(write_phase && (xfer_type == TT_WRITE));

  assign cmd_unused  = ^{command_q[7:6], command_q[4:3], command_q[1:0]};
  assign mode_unused = ^active_mode[MODE_SEL_LSB +: 2];

endmodule

// File: tb/tb_kf8237_timing_and_control.sv
// Self-checking bench for kf8237_timing_and_control: per-cycle vector table through a
// scoreboard queue, plus a hand-written master-clear sequence with bounded waits.
module tb_kf8237_timing_and_control;

  typedef struct packed {
    logic       rst_n;
    logic       wcmd;
    logic       wmode;
    logic       rds;
    logic [7:0] data;
    logic [3:0] enc;
    logic       hlda;
    logic       rdy;
    logic       eop_n;
    logic       uf;
  } in_t;

  // strb = {memory_read_n, memory_write_n, io_read_n_out, io_write_n_out}
  typedef struct packed {
    logic       hrq;
    logic [3:0] ack;
    logic [3:0] trs;
    logic       dec;
    logic       aen;
    logic       adstb;
    logic       nw;
    logic       init;
    logic       eopi;
    logic       eopo_n;
    logic [3:0] strb;
    logic       lock;
    logic [7:0] status;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data;
  logic       wcmd, wmode, mclr, rds;
  logic [3:0] enc;
  logic       hlda, rdy, eop_n, uf;
  logic       hold_request;
  logic [3:0] dma_ack, trs;
  logic       dec, nw, init, eopi, eopo_n, aen, adstb;
  logic       mr_n, mw_n, ior_n, iow_n, lock;
  logic [7:0] status;

  always #5 clk = ~clk;

  kf8237_timing_and_control dut (
    .clock                       (clk),
    .reset_n                     (reset_n),
    .internal_data_bus           (data),
    .write_command_register      (wcmd),
    .write_mode_register         (wmode),
    .master_clear                (mclr),
    .read_status_register        (rds),
    .encoded_dma                 (enc),
    .hold_acknowledge            (hlda),
    .ready                       (rdy),
    .end_of_process_in           (eop_n),
    .underflow                   (uf),
    .hold_request                (hold_request),
    .dma_acknowledge_internal    (dma_ack),
    .transfer_register_select    (trs),
    .decrement_address_config    (dec),
    .next_word                   (nw),
    .initialize_current_register (init),
    .end_of_process_internal     (eopi),
    .end_of_process_out          (eopo_n),
    .address_enable              (aen),
    .address_strobe              (adstb),
    .memory_read_n               (mr_n),
    .memory_write_n              (mw_n),
    .io_read_n_out               (ior_n),
    .io_write_n_out              (iow_n),
    .lock_bus_control            (lock),
    .status                      (status)
  );

  function automatic in_t ix(input logic r, input logic wc, input logic wm, input logic rs,
                             input logic [7:0] d, input logic [3:0] e, input logic h,
                             input logic rd, input logic ep, input logic u);
    in_t v;
    v = '{rst_n: r, wcmd: wc, wmode: wm, rds: rs, data: d, enc: e, hlda: h, rdy: rd,
          eop_n: ep, uf: u};
    return v;
  endfunction

  function automatic in_t I(input logic [3:0] e, input logic h, input logic rd,
                            input logic ep, input logic u);
    return ix(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, e, h, rd, ep, u);
  endfunction

  function automatic in_t W(input logic wc, input logic wm, input logic [7:0] d);
    return ix(1'b1, wc, wm, 1'b0, d, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic in_t R();
    return ix(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic out_t E_idle(input logic [3:0] tc);
    out_t o;
    o = '{hrq: 1'b0, ack: 4'h0, trs: 4'h0, dec: 1'b0, aen: 1'b0, adstb: 1'b0, nw: 1'b0,
          init: 1'b0, eopi: 1'b0, eopo_n: 1'b1, strb: 4'hF, lock: 1'b0, status: {4'h0, tc}};
    return o;
  endfunction

  function automatic out_t E_s0(input logic [3:0] tc);
    out_t o;
    o = E_idle(tc);
    o.hrq = 1'b1;
    return o;
  endfunction

  function automatic out_t E_bus(input logic [3:0] ack, input logic d, input logic ae,
                                 input logic as, input logic [3:0] strb, input logic n,
                                 input logic ei, input logic eo, input logic in_,
                                 input logic [3:0] tc);
    out_t o;
    o = '{hrq: 1'b1, ack: ack, trs: ack, dec: d, aen: ae, adstb: as, nw: n, init: in_,
          eopi: ei, eopo_n: eo, strb: strb, lock: 1'b1, status: {4'h0, tc}};
    return o;
  endfunction

  // Status high nibble mirrors encoded_dma in the same cycle.
  task automatic add(input in_t i, input out_t e);
    vec_t v;
    e.status[7:4] = i.enc;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic build();
    add(ix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0), E_idle(4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // ch1 single read, terminal count on the only word
    add(W(0, 1, 8'h49), E_idle(4'h0));
    add(W(1, 0, 8'h00), E_idle(4'h0));
    add(I(4'h2, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h2, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h2, 1, 1, 1, 0), E_bus(4'h2, 0, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h2, 1, 1, 1, 1), E_bus(4'h2, 0, 1, 0, 4'b0111, 0, 0, 1, 0, 4'h0));
    add(I(4'h2, 1, 1, 1, 1), E_bus(4'h2, 0, 1, 0, 4'b0110, 0, 0, 1, 0, 4'h0));
    add(I(4'h2, 1, 1, 1, 1), E_bus(4'h2, 0, 1, 0, 4'b0110, 1, 1, 0, 0, 4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h2));
    add(R(), E_idle(4'h2));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // ch0 block write, extended write, two wait states, two words
    add(W(0, 1, 8'h84), E_idle(4'h0));
    add(W(1, 0, 8'h20), E_idle(4'h0));
    add(I(4'h1, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 0, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 0, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 1, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 1), E_bus(4'h1, 0, 1, 0, 4'b1001, 1, 1, 0, 0, 4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h1));
    add(W(1, 0, 8'h00), E_idle(4'h1));
    add(R(), E_idle(4'h1));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // ch0 block read, external EOP during word 3
    add(W(0, 1, 8'h88), E_idle(4'h0));
    add(I(4'h1, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    for (int w = 0; w < 3; w++) begin
      add(I(4'h1, 1, 1, (w != 2), 0), E_bus(4'h1, 0, 1, 0, 4'b0111, 0, 0, 1, 0, 4'h0));
      add(I(4'h1, 1, 1, (w != 2), 0), E_bus(4'h1, 0, 1, 0, 4'b0110, 0, 0, 1, 0, 4'h0));
      add(I(4'h1, 1, 1, (w != 2), 0),
          E_bus(4'h1, 0, 1, 0, 4'b0110, 1, (w == 2), 1, 0, 4'h0));
    end
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // ch2 single verify, autoinit + decrement, terminal count
    add(W(0, 1, 8'h72), E_idle(4'h0));
    add(I(4'h4, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h4, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h4, 1, 1, 1, 0), E_bus(4'h4, 1, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h4, 1, 1, 1, 0), E_bus(4'h4, 1, 1, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h4, 1, 1, 1, 0), E_bus(4'h4, 1, 1, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h4, 1, 1, 1, 1), E_bus(4'h4, 1, 1, 0, 4'hF, 1, 1, 0, 1, 4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h4));
    add(R(), E_idle(4'h4));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // ch3 cascade
    add(W(0, 1, 8'hC3), E_idle(4'h0));
    add(I(4'h8, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h8, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h8, 1, 1, 1, 0), E_bus(4'h8, 0, 0, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h8, 1, 1, 1, 0), E_bus(4'h8, 0, 0, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h0, 1, 1, 1, 0), E_bus(4'h8, 0, 0, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // reset while in SW, then a fresh demand-verify service
    add(W(0, 1, 8'h84), E_idle(4'h0));
    add(I(4'h1, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1101, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 1, 0, 1, 0), E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(ix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0),
        E_bus(4'h1, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 4'h0));
    add(I(4'h1, 0, 1, 1, 0), E_idle(4'h0));
    add(I(4'h1, 1, 1, 1, 0), E_s0(4'h0));
    add(I(4'h0, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 1, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h0, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h0, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'hF, 0, 0, 1, 0, 4'h0));
    add(I(4'h0, 1, 1, 1, 0), E_bus(4'h1, 0, 1, 0, 4'hF, 1, 1, 1, 0, 4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
    // controller disable written in the request cycle, then re-enabled; request withdrawn in S0
    add(ix(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0), E_idle(4'h0));
    add(I(4'h1, 0, 1, 1, 0), E_idle(4'h0));
    add(ix(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0), E_idle(4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_s0(4'h0));
    add(I(4'h0, 0, 1, 1, 0), E_idle(4'h0));
  endtask

  task automatic apply(input in_t v);
    reset_n = v.rst_n;
    wcmd    = v.wcmd;
    wmode   = v.wmode;
    rds     = v.rds;
    data    = v.data;
    enc     = v.enc;
    hlda    = v.hlda;
    rdy     = v.rdy;
    eop_n   = v.eop_n;
    uf      = v.uf;
    mclr    = 1'b0;
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{hrq: hold_request, ack: dma_ack, trs: trs, dec: dec, aen: aen, adstb: adstb,
          nw: nw, init: init, eopi: eopi, eopo_n: eopo_n, strb: {mr_n, mw_n, ior_n, iow_n},
          lock: lock, status: status};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    out_t got;
    out_t exp;
    int   n;
    apply(ix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0));
    build();
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      apply(vecs[k].i);
      exp_q.push_back(vecs[k].e);
      @(negedge clk);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h (hrq,ack,trs,dec,aen,adstb,nw,init,eopi,eopo_n,strb,lock,status)",
                 k, got, exp);
      end
    end

    // master clear in the middle of a ch1 single-read service
    @(posedge clk); #1;
    apply(W(0, 1, 8'h49));
    @(posedge clk); #1;
    apply(I(4'h2, 0, 1, 1, 0));
    n = 0;
    while (!hold_request && n < 8) begin @(posedge clk); #1; n++; end
    check("mclr_hrq_wait", {31'd0, hold_request}, 32'd1);
    hlda = 1'b1;
    n = 0;
    while (mr_n && n < 8) begin @(posedge clk); #1; n++; end
    check("mclr_read_strobe_wait", {31'd0, mr_n}, 32'd0);
    mclr = 1'b1;
    enc  = 4'h0;
    hlda = 1'b0;
    @(posedge clk); #1;
    mclr = 1'b0;
    @(negedge clk);
    check("mclr_outputs", {18'd0, hold_request, dma_ack, aen, adstb, nw, eopi, eopo_n,
                           mr_n, iow_n, lock},
          {18'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    check("mclr_status", {24'd0, status}, 32'h00);
    // mode registers are cleared too: ch1 now runs as verify with no strobes
    @(posedge clk); #1;
    enc  = 4'h2;
    hlda = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mclr_mode_cleared", {28'd0, aen, mr_n, iow_n, adstb}, {28'd0, 4'b1110});
    @(posedge clk); #1;
    enc  = 4'h0;
    hlda = 1'b0;
    n = 0;
    while (hold_request && n < 10) begin @(posedge clk); #1; n++; end
    check("demand_drop_idle", {31'd0, hold_request}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
